// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side write signals of fifo_wr_arbiter.
//   master : the arbiter (drives gnt, fifo_wr_en, fifo_data_in)
//   slave  : producers plus FIFO (drive req, req_data and the FIFO status flags)
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;

  modport master (
    input  req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output gnt, fifo_wr_en, fifo_data_in
  );

  modport slave (
    output req, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  gnt, fifo_wr_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// Each grant covers a burst of up to MAX_BURST words. FIFO full/almostfull
// provide backpressure; wr_ack/overflow are watched and raise sticky errors.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (master) : req/req_data/gnt producer handshake and FIFO write port
//   owner        : index of the current or last granted producer
//   busy         : high while a burst is in progress
//   err_overflow : sticky, FIFO reported overflow
//   err_ack      : sticky, a write was not acknowledged
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fifo_wr_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       err_overflow,
  output logic                       err_ack
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [OW-1:0] rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic          wr_en_d1;

  logic          pick_vld;
  logic [OW-1:0] pick_idx;
  logic [OW-1:0] owner_inc;
  logic          space_ok;
  logic          accept;
  logic          last_word;

  // First requester found scanning upward from rr_ptr with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && bus.req[OW'((32'(rr_ptr) + i) % NUM_REQ)]) begin
        pick_vld = 1'b1;
        pick_idx = OW'((32'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign owner_inc = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
  assign last_word = (burst_cnt + BW'(1)) == BW'(MAX_BURST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (accept) begin
          if (last_word) begin
            state_nxt = S_IDLE;
          end
        end else if (!bus.req[owner]) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: the grant is combinational so the word is consumed this cycle.
  // A write already in flight while almostfull would take the last slot, so
  // the next word is held back.
  always_comb begin
    space_ok = !bus.fifo_full && !(bus.fifo_wr_en && bus.fifo_almostfull);
    accept   = 1'b0;
    bus.gnt  = '0;
    if (rst_n && (state == S_BURST) && bus.req[owner] && space_ok) begin
      accept         = 1'b1;
      bus.gnt[owner] = 1'b1;
    end
  end

  assign busy = (state == S_BURST);

  // Ownership, round-robin pointer, burst counter and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr           <= '0;
      burst_cnt        <= '0;
      owner            <= '0;
      bus.fifo_wr_en   <= 1'b0;
      bus.fifo_data_in <= '0;
    end else begin
      bus.fifo_wr_en <= accept;
      if (accept) begin
        bus.fifo_data_in <= bus.req_data[32'(owner) * FIFO_WIDTH +: FIFO_WIDTH];
        burst_cnt        <= burst_cnt + BW'(1);
      end
      if ((state == S_IDLE) && pick_vld) begin
        owner     <= pick_idx;
        burst_cnt <= '0;
      end
      if ((state == S_BURST) && (state_nxt == S_IDLE)) begin
        rr_ptr <= owner_inc;
      end
    end
  end

  // Sticky error flags; a write issued on cycle N must be acked on cycle N+1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_overflow <= 1'b0;
      err_ack      <= 1'b0;
      wr_en_d1     <= 1'b0;
    end else begin
      err_overflow <= err_overflow | bus.fifo_overflow;
      wr_en_d1     <= bus.fifo_wr_en;
      err_ack      <= err_ack | (wr_en_d1 && !bus.fifo_wr_ack);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: expected grants come from the
// stimulus script; granted words are queued and matched against fifo_data_in.
module tb_fifo_wr_arbiter;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned FIFO_WIDTH = 16;
  localparam int unsigned MAX_BURST  = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] owner;
  logic       busy;
  logic       err_overflow;
  logic       err_ack;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .FIFO_WIDTH(FIFO_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .owner       (owner),
    .busy        (busy),
    .err_overflow(err_overflow),
    .err_ack     (err_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned           checks = 0;
  int unsigned           errors = 0;
  logic [FIFO_WIDTH-1:0] sb_q[$];
  logic                  exp_wr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: check gnt and the write port at negedge, queue granted words,
  // then advance to just after the next posedge with fresh producer data.
  task automatic step(input logic [NUM_REQ-1:0] exp_gnt, input string tag);
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(exp_gnt));
    chk({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 32'(exp_wr));
    if (bus.fifo_wr_en) begin
      if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 32'(1), 32'(0));
      else                  chk({tag, "_data"}, 32'(bus.fifo_data_in), 32'(sb_q.pop_front()));
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (exp_gnt[i]) sb_q.push_back(bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH]);
    end
    exp_wr = (exp_gnt != '0);
    @(posedge clk);
    #1;
    bus.req_data = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n               = 1'b0;
    bus.req             = 4'b1111;
    bus.req_data        = {$urandom, $urandom};
    bus.fifo_full       = 1'b0;
    bus.fifo_almostfull = 1'b0;
    bus.fifo_wr_ack     = 1'b1;
    bus.fifo_overflow   = 1'b0;
    @(posedge clk);
    #1;

    // Reset with all producers requesting.
    step(4'b0000, "rst");
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'(0));
    chk("rst_err_ovf", 32'(err_overflow), 32'(0));
    chk("rst_err_ack", 32'(err_ack), 32'(0));
    rst_n = 1'b1;

    // Round robin: full bursts of 4 with one idle cycle per grant.
    for (int p = 0; p < int'(NUM_REQ); p++) begin
      step(4'b0000, "rr_idle");
      chk("rr_busy", 32'(busy), 32'(1));
      chk("rr_owner", 32'(owner), 32'(p));
      for (int k = 0; k < int'(MAX_BURST); k++) step(4'(1 << p), "rr_word");
    end
    step(4'b0000, "rr_idle");
    step(4'b0001, "rr_wrap");
    bus.req = 4'b0000;
    step(4'b0000, "rr_drop");
    step(4'b0000, "idle_noreq");
    chk("idle_busy", 32'(busy), 32'(0));

    // Early release by producer 2; producer 3 is next.
    bus.req = 4'b0100;
    step(4'b0000, "er_idle");
    step(4'b0100, "er_w0");
    step(4'b0100, "er_w1");
    bus.req = 4'b0000;
    step(4'b0000, "er_drop");
    bus.req = 4'b1001;
    step(4'b0000, "er_next_idle");
    step(4'b1000, "er_next3");
    bus.req = 4'b0000;
    step(4'b0000, "er_drop3");

    // Early release by producer 2 again; nobody at 3 so wrap to 0.
    bus.req = 4'b0100;
    step(4'b0000, "er2_idle");
    step(4'b0100, "er2_w0");
    step(4'b0100, "er2_w1");
    bus.req = 4'b0000;
    step(4'b0000, "er2_drop");
    bus.req = 4'b0011;
    step(4'b0000, "er2_wrap_idle");
    step(4'b0001, "er2_wrap0");
    bus.req = 4'b0010;
    step(4'b0000, "er2_drop0");
    step(4'b0000, "bp_idle");

    // Backpressure on producer 1's burst.
    step(4'b0010, "bp_w0");
    bus.fifo_almostfull = 1'b1;
    step(4'b0000, "bp_af_stall");
    step(4'b0010, "bp_af_w1");
    step(4'b0000, "bp_af_stall2");
    bus.fifo_almostfull = 1'b0;
    bus.fifo_full       = 1'b1;
    for (int k = 0; k < 5; k++) step(4'b0000, "bp_full");
    chk("bp_busy", 32'(busy), 32'(1));
    bus.fifo_full = 1'b0;
    step(4'b0010, "bp_w2");
    step(4'b0010, "bp_w3");
    step(4'b0000, "bp_end_idle");
    chk("bp_err_ovf", 32'(err_overflow), 32'(0));

    // Reset after the 2nd word of producer 1's burst.
    step(4'b0010, "mr_w0");
    step(4'b0010, "mr_w1");
    rst_n = 1'b0;
    step(4'b0000, "mr_rst");
    rst_n   = 1'b1;
    bus.req = 4'b0011;
    chk("mr_wr_en", 32'(bus.fifo_wr_en), 32'(0));
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_owner", 32'(owner), 32'(0));
    step(4'b0000, "mr_idle");
    step(4'b0001, "mr_grant0");
    bus.req = 4'b0000;
    step(4'b0000, "mr_drop");

    // Overflow flag is sticky.
    chk("ef_ovf_pre", 32'(err_overflow), 32'(0));
    chk("ef_ack_pre", 32'(err_ack), 32'(0));
    bus.fifo_overflow = 1'b1;
    step(4'b0000, "ef_ovf");
    bus.fifo_overflow = 1'b0;
    chk("ef_ovf_set", 32'(err_overflow), 32'(1));
    step(4'b0000, "ef_ovf_hold");
    chk("ef_ovf_held", 32'(err_overflow), 32'(1));

    // Unacknowledged write raises err_ack.
    bus.fifo_wr_ack = 1'b0;
    bus.req         = 4'b0001;
    step(4'b0000, "ea_idle");
    step(4'b0001, "ea_grant");
    bus.req = 4'b0000;
    step(4'b0000, "ea_wr");
    chk("ea_ack_early", 32'(err_ack), 32'(0));
    step(4'b0000, "ea_d1");
    chk("ea_ack_set", 32'(err_ack), 32'(1));
    step(4'b0000, "ea_hold");
    chk("ea_ack_held", 32'(err_ack), 32'(1));

    chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one FIFO write port among NUM_REQ producers.
- Grants one requester at a time for a burst of up to MAX_BURST words.
- Drives the FIFO's wr_en/data_in from registers and uses the FIFO's full/almostfull flags for backpressure, so the FIFO never overflows.
- Monitors wr_ack/overflow and raises sticky error flags.

Parameters:
- NUM_REQ, 4, number of producers (>=2).
- FIFO_WIDTH, 16, data word width; matches the FIFO.
- MAX_BURST, 4, maximum words accepted per grant (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- req  in  NUM_REQ  per-producer request; word valid on req_data.
- req_data  in  NUM_REQ*FIFO_WIDTH  producer i data at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- gnt  out  NUM_REQ  one-hot, combinational; gnt[i]=1 means producer i's word is consumed this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_almostfull  in  1  FIFO almostfull flag (count == depth-1).
- fifo_wr_ack  in  1  FIFO write acknowledge.
- fifo_overflow  in  1  FIFO overflow flag.
- fifo_wr_en  out  1  registered write enable to the FIFO.
- fifo_data_in  out  FIFO_WIDTH  registered write data to the FIFO.
- owner  out  $clog2(NUM_REQ)  index of the current or last granted producer.
- busy  out  1  1 while in BURST.
- err_overflow  out  1  sticky; set when fifo_overflow is seen.
- err_ack  out  1  sticky; set when a write is not acknowledged.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State=IDLE; rr_ptr=0; burst_cnt=0; owner=0; busy=0.
  - fifo_wr_en=0; fifo_data_in=0; err_overflow=0; err_ack=0; wr_en_d1=0.
  - gnt=0 combinationally while rst_n=0.
  - A reset mid-burst discards the burst. Nothing already issued is cancelled.
- FSM IDLE:
  - If any req bit is set, pick the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Next edge: owner=picked index, burst_cnt=0, state=BURST.
  - No word is accepted in IDLE. Each new grant costs exactly one idle cycle.
- FSM BURST:
  - space_ok = !fifo_full && !(fifo_wr_en && fifo_almostfull). This blocks the write that would land on an in-flight last slot.
  - accept = req[owner] && space_ok. gnt[owner] = accept; all other gnt bits = 0.
  - On accept:
    - Next edge: fifo_wr_en=1, fifo_data_in=req_data[owner slice], burst_cnt+1.
    - If burst_cnt+1 == MAX_BURST: state=IDLE, rr_ptr=(owner+1) mod NUM_REQ.
  - Otherwise:
    - Next edge: fifo_wr_en=0.
    - If !req[owner]: state=IDLE, rr_ptr=(owner+1) mod NUM_REQ.
    - If req[owner] && !space_ok (stall): stay in BURST; burst_cnt unchanged. Stalls do not end or count against the burst.
- Write latency: accepted word appears on fifo_data_in with fifo_wr_en=1 exactly 1 cycle after gnt.
- Issue rate: at most one write per cycle.
- rr_ptr wraps: NUM_REQ-1 +1 -> 0.
- burst_cnt width is $clog2(MAX_BURST+1); it never exceeds MAX_BURST.
- Simultaneous requests: only the owner is served. Others wait at most (NUM_REQ-1)*(MAX_BURST+1) non-stalled cycles.
- A producer that drops and reasserts req during its burst loses the grant.
- Error flags:
  - err_overflow <= err_overflow | fifo_overflow.
  - wr_en_d1 <= fifo_wr_en.
  - err_ack <= err_ack | (wr_en_d1 && !fifo_wr_ack).
  - Both flags clear only on reset.
- busy = (state == BURST).

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, fifo_wr_en=0, owner=0, busy=0, err flags 0. After release, first grant goes to producer 0.
- Round robin: req=4'b1111 held, MAX_BURST=4, FIFO never full -> gnt sequence is 0 x4, idle, 1 x4, idle, 2 x4, idle, 3 x4, idle, 0; fifo_data_in carries matching data one cycle later.
- Early release: producer 2 alone supplies 2 words then drops req -> exactly 2 writes; next grant goes to producer 3 if requesting, else wraps to 0.
- Backpressure: fifo_almostfull=1 while fifo_wr_en=1 -> gnt=0 that cycle. Hold fifo_full=1 for 5 cycles -> no gnt, burst_cnt held, fifo_wr_en=0. On release, burst resumes and completes the remaining words. err_overflow stays 0.
- Mid-burst reset: assert rst_n=0 after the 2nd word of producer 1's burst -> next cycle fifo_wr_en=0, state IDLE, rr_ptr=0. Post-reset grant goes to producer 0 if requesting.
- Error flags: force fifo_overflow=1 for 1 cycle -> err_overflow=1 and held. Issue a write with fifo_wr_ack held 0 -> err_ack=1 two cycles after gnt.
